// File: rtl/count_event_pkg.sv
// Shared types and constants for the count-change event recorder.
package count_event_pkg;

  localparam int COUNT_WIDTH  = 8;
  localparam int TS_WIDTH_DEF = 16;

  // A 255 -> 0 step of the upstream counter is a genuine wrap.
  localparam logic [COUNT_WIDTH-1:0] WRAP_FROM = 8'hFF;
  localparam logic [COUNT_WIDTH-1:0] WRAP_TO   = 8'h00;

  // Layout of one buffered event, most significant field first.
  typedef struct packed {
    logic [COUNT_WIDTH-1:0]  count;
    logic [TS_WIDTH_DEF-1:0] ts;
    logic                    wrap;
  } count_event_t;

endpackage

// File: rtl/event_fifo.sv
// Parameterised synchronous FIFO with extended pointers and level output.
// When empty, the read data holds the last head value that was presented.
module event_fifo #(
  parameter int DW    = 25,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam int PW = AW + 1;
  localparam logic [AW:0] FULL_LVL = PW'(DEPTH);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [DW-1:0] r_hold;

  logic [AW:0]   w_level;
  logic          w_empty;
  logic          w_full;
  logic          w_do_pop;
  logic          w_do_push;
  logic [DW-1:0] w_head;

  // Occupancy and the gated push/pop strobes; flush overrides both.
  always_comb begin
    w_level   = r_wr_ptr - r_rd_ptr;
    w_empty   = (w_level == {PW{1'b0}});
    w_full    = (w_level == FULL_LVL);
    w_do_pop  = pop_i && !w_empty && !flush_i;
    w_do_push = push_i && (!w_full || w_do_pop) && !flush_i;
    w_head    = r_mem[r_rd_ptr[AW-1:0]];
  end

  // Pointer update: flush empties, otherwise advance on push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else if (flush_i) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage write port; contents need no reset because empty masks them.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din_i;
  end

  // Remember the presented head so the outputs hold once the FIFO drains.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold <= {DW{1'b0}};
    end else if (!w_empty) begin
      r_hold <= w_head;
    end
  end

  // Read port: live head while occupied, held value while empty.
  always_comb begin
    dout_o = r_hold;
    if (!w_empty) begin
      dout_o = w_head;
    end else begin
      dout_o = r_hold;
    end
  end

  assign full_o  = w_full;
  assign empty_o = w_empty;
  assign level_o = w_level;

endmodule

// File: rtl/count_event_fifo.sv
// Watches an 8-bit counter bus, timestamps every change, buffers the events
// in a small FIFO for a valid/ready consumer and flags threshold crossings.
module count_event_fifo
  import count_event_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TS_WIDTH  = 16,
  parameter int LVL_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   capture_en_i,
  input  logic [COUNT_WIDTH-1:0] count_i,
  input  logic [COUNT_WIDTH-1:0] threshold_i,
  input  logic                   clear_i,
  output logic                   event_valid_o,
  input  logic                   event_ready_i,
  output logic [COUNT_WIDTH-1:0] event_count_o,
  output logic [TS_WIDTH-1:0]    event_ts_o,
  output logic                   event_wrap_o,
  output logic                   overflow_o,
  output logic                   threshold_hit_o,
  output logic [LVL_WIDTH-1:0]   level_o
);

  localparam int DW = COUNT_WIDTH + TS_WIDTH + 1;
  localparam logic [TS_WIDTH-1:0] TS_ONE = {{(TS_WIDTH-1){1'b0}}, 1'b1};

  logic [COUNT_WIDTH-1:0] r_prev_count;
  logic [TS_WIDTH-1:0]    r_ts;
  logic                   r_overflow;
  logic                   r_thr_hit;

  logic                   w_change;
  logic                   w_event;
  logic                   w_wrap;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_empty;
  logic [DW-1:0]          w_entry;
  logic [DW-1:0]          w_head;

  // Change detection and the push/drop decision; clear discards any event.
  always_comb begin
    w_change = (count_i != r_prev_count);
    w_event  = w_change && capture_en_i;
    w_wrap   = (r_prev_count == WRAP_FROM) && (count_i == WRAP_TO);
    w_entry  = {count_i, r_ts, w_wrap};
    w_pop    = !w_empty && event_ready_i;
    w_push   = w_event && !clear_i && (!w_full || w_pop);
    w_drop   = w_event && !clear_i && w_full && !w_pop;
  end

  // Free-running timestamp, independent of capture enable.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) r_ts <= {TS_WIDTH{1'b0}};
    else           r_ts <= r_ts + TS_ONE;
  end

  // Previous sample of the counter bus, reloaded every cycle.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) r_prev_count <= {COUNT_WIDTH{1'b0}};
    else           r_prev_count <= count_i;
  end

  // Sticky overflow: set by a dropped event, cleared only by clear or reset.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni)   r_overflow <= 1'b0;
    else if (clear_i) r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
  end

  // One-cycle threshold pulse for any captured change landing on the threshold.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) r_thr_hit <= 1'b0;
    else           r_thr_hit <= w_event && (count_i == threshold_i);
  end

  event_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_ni  (reset_ni),
    .push_i  (w_push),
    .pop_i   (event_ready_i),
    .flush_i (clear_i),
    .din_i   (w_entry),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (level_o)
  );

  assign event_valid_o   = !w_empty;
  assign event_count_o   = w_head[DW-1 -: COUNT_WIDTH];
  assign event_ts_o      = w_head[TS_WIDTH:1];
  assign event_wrap_o    = w_head[0];
  assign overflow_o      = r_overflow;
  assign threshold_hit_o = r_thr_hit;

endmodule

// File: tb/tb_count_event_fifo.sv
// Scoreboard bench: stimulus queues expected events, a monitor checks pops.
module tb_count_event_fifo;

  typedef struct packed {
    logic [7:0]  c;
    logic [15:0] ts;
    logic        w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        capture_en_i;
  logic [7:0]  count_i;
  logic [7:0]  threshold_i;
  logic        clear_i;
  logic        event_valid_o;
  logic        event_ready_i;
  logic [7:0]  event_count_o;
  logic [15:0] event_ts_o;
  logic        event_wrap_o;
  logic        overflow_o;
  logic        threshold_hit_o;
  logic [2:0]  level_o;

  exp_t        exp_q[$];
  logic [15:0] m_ts;
  int          n_chk = 0;
  int          n_pass = 0;

  count_event_fifo dut (
    .clock_i         (clk),
    .reset_ni        (rst_n),
    .capture_en_i    (capture_en_i),
    .count_i         (count_i),
    .threshold_i     (threshold_i),
    .clear_i         (clear_i),
    .event_valid_o   (event_valid_o),
    .event_ready_i   (event_ready_i),
    .event_count_o   (event_count_o),
    .event_ts_o      (event_ts_o),
    .event_wrap_o    (event_wrap_o),
    .overflow_o      (overflow_o),
    .threshold_hit_o (threshold_hit_o),
    .level_o         (level_o)
  );

  always #5 clk = ~clk;

  // Reference cycle counter used to stamp expected events.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_ts <= 16'd0;
    else        m_ts <= m_ts + 16'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic chg(input logic [7:0] v, input logic w, input bit pushed);
    count_i = v;
    if (pushed) exp_q.push_back('{c: v, ts: m_ts, w: w});
    step();
  endtask

  // Monitor: every accepted head entry must match the scoreboard front.
  always @(negedge clk) begin
    if (rst_n && event_valid_o && event_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {24'd0, event_count_o}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_count", {24'd0, event_count_o}, {24'd0, e.c});
        chk("pop_ts",    {16'd0, event_ts_o},    {16'd0, e.ts});
        chk("pop_wrap",  {31'd0, event_wrap_o},  {31'd0, e.w});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; capture_en_i = 1'b0; count_i = 8'h00; threshold_i = 8'hAA;
    clear_i = 1'b0; event_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    look();
    chk("rst_valid", {31'd0, event_valid_o},   32'd0);
    chk("rst_count", {24'd0, event_count_o},   32'd0);
    chk("rst_ts",    {16'd0, event_ts_o},      32'd0);
    chk("rst_wrap",  {31'd0, event_wrap_o},    32'd0);
    chk("rst_ovf",   {31'd0, overflow_o},      32'd0);
    chk("rst_hit",   {31'd0, threshold_hit_o}, 32'd0);
    chk("rst_level", {29'd0, level_o},         32'd0);

    // Single event at ts = 5
    step(); rst_n = 1'b1; capture_en_i = 1'b1;
    repeat (5) step();
    chg(8'h01, 1'b0, 1'b1);
    look();
    chk("single_valid", {31'd0, event_valid_o}, 32'd1);
    chk("single_count", {24'd0, event_count_o}, 32'd1);
    chk("single_ts",    {16'd0, event_ts_o},    32'd5);
    chk("single_wrap",  {31'd0, event_wrap_o},  32'd0);
    chk("single_level", {29'd0, level_o},       32'd1);
    step(); event_ready_i = 1'b1;
    step(); event_ready_i = 1'b0;
    look();
    chk("single_drained", {31'd0, event_valid_o}, 32'd0);

    // Wrap vs. upstream reset jump
    step(); event_ready_i = 1'b1;
    chg(8'hFF, 1'b0, 1'b1);
    chg(8'h00, 1'b1, 1'b1);
    chg(8'h37, 1'b0, 1'b1);
    chg(8'h00, 1'b0, 1'b1);
    step(); event_ready_i = 1'b0;
    look();
    chk("wrap_level", {29'd0, level_o}, 32'd0);

    // Fill, then two drops
    step();
    chg(8'h01, 1'b0, 1'b1);
    chg(8'h02, 1'b0, 1'b1);
    chg(8'h03, 1'b0, 1'b1);
    chg(8'h04, 1'b0, 1'b1);
    chg(8'h05, 1'b0, 1'b0);
    chg(8'h06, 1'b0, 1'b0);
    look();
    chk("full_level", {29'd0, level_o},       32'd4);
    chk("full_ovf",   {31'd0, overflow_o},    32'd1);
    chk("full_head",  {24'd0, event_count_o}, 32'd1);

    // Push while full with simultaneous pop
    step(); event_ready_i = 1'b1;
    chg(8'h07, 1'b0, 1'b1);
    event_ready_i = 1'b0;
    look();
    chk("pp_level", {29'd0, level_o},    32'd4);
    chk("pp_ovf",   {31'd0, overflow_o}, 32'd1);
    step(); event_ready_i = 1'b1;
    repeat (4) step();
    event_ready_i = 1'b0;
    look();
    chk("drain_level", {29'd0, level_o},    32'd0);
    chk("drain_ovf",   {31'd0, overflow_o}, 32'd1);

    // Clear together with a change
    step();
    chg(8'h08, 1'b0, 1'b1);
    chg(8'h09, 1'b0, 1'b1);
    clear_i = 1'b1; count_i = 8'h0A; exp_q.delete();
    step(); clear_i = 1'b0;
    look();
    chk("clr_level", {29'd0, level_o},       32'd0);
    chk("clr_ovf",   {31'd0, overflow_o},    32'd0);
    chk("clr_valid", {31'd0, event_valid_o}, 32'd0);
    step(); look();
    chk("clr_nopush", {29'd0, level_o}, 32'd0);

    // Threshold with capture enabled
    step(); threshold_i = 8'h03;
    chg(8'h02, 1'b0, 1'b1);
    look();
    chk("thr_pre", {31'd0, threshold_hit_o}, 32'd0);
    step();
    chg(8'h03, 1'b0, 1'b1);
    look();
    chk("thr_hit", {31'd0, threshold_hit_o}, 32'd1);
    step(); look();
    chk("thr_once", {31'd0, threshold_hit_o}, 32'd0);
    step(); event_ready_i = 1'b1;
    step(); step();
    event_ready_i = 1'b0; capture_en_i = 1'b0;
    chg(8'h02, 1'b0, 1'b0);
    look();
    chk("thr_dis_a", {31'd0, threshold_hit_o}, 32'd0);
    step();
    chg(8'h03, 1'b0, 1'b0);
    look();
    chk("thr_dis_b", {31'd0, threshold_hit_o}, 32'd0);
    step(); look();
    chk("thr_dis_c",   {31'd0, threshold_hit_o}, 32'd0);
    chk("thr_dis_lvl", {29'd0, level_o},         32'd0);

    // Reset mid-operation with a nonzero upstream count
    step(); capture_en_i = 1'b1;
    chg(8'h04, 1'b0, 1'b1);
    rst_n = 1'b0; exp_q.delete();
    #1;
    chk("arst_level", {29'd0, level_o},       32'd0);
    chk("arst_valid", {31'd0, event_valid_o}, 32'd0);
    step();
    rst_n = 1'b1;
    exp_q.push_back('{c: 8'h04, ts: 16'd0, w: 1'b0});
    event_ready_i = 1'b1;
    step(); step();
    look();
    chk("rel_level", {29'd0, level_o}, 32'd0);
    step(); event_ready_i = 1'b0;
    repeat (2) step();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/count_event_fifo.md
# count_event_fifo

Downstream companion to the 8-bit prescaled event counter. It watches the counter's `count_o` bus, detects each change, and stamps each change with a free-running cycle timestamp and a wrap flag. It buffers these events in a small FIFO and hands them to a consumer over a valid/ready interface. It also raises a one-cycle pulse when the counter reaches a programmable threshold.

## Interface
Parameters:
- `DEPTH`, 4: number of FIFO entries. Must be a power of two and at least 2.
- `TS_WIDTH`, 16: width of the timestamp counter.
- `LVL_WIDTH`, `$clog2(DEPTH)+1`: width of the level output. Derived; do not override.

Ports:
- `clock_i` in 1: the single clock. All logic is on the rising edge.
- `reset_ni` in 1: asynchronous, active-low reset.
- `capture_en_i` in 1: when high, detected changes are recorded as events.
- `count_i` in 8: connected to the counter's `count_o`.
- `threshold_i` in 8: value that triggers `threshold_hit_o`. Quasi-static.
- `clear_i` in 1: synchronous flush of the FIFO and the overflow flag.
- `event_valid_o` out 1: the head entry is present.
- `event_ready_i` in 1: the consumer accepts the head entry.
- `event_count_o` out 8: count value of the head entry.
- `event_ts_o` out `TS_WIDTH`: timestamp of the head entry.
- `event_wrap_o` out 1: the head entry was a 255→0 transition.
- `overflow_o` out 1: sticky flag; at least one event was dropped.
- `threshold_hit_o` out 1: one-cycle pulse.
- `level_o` out `LVL_WIDTH`: number of entries currently held.

## Operation
- Reset (`reset_ni` low) acts immediately. Every output goes to 0: `event_valid_o`, `event_count_o`, `event_ts_o`, `event_wrap_o`, `overflow_o`, `threshold_hit_o` and `level_o`. The internal `prev_count`, `ts` and the FIFO pointers also go to 0.
- `ts` increments by 1 on every clock edge and wraps modulo 2^`TS_WIDTH`. `capture_en_i` has no effect on it.
- `prev_count` loads `count_i` on every edge, regardless of the enable, clear or FIFO state.
- A change is detected when `count_i != prev_count`.
- A change becomes an event when `capture_en_i` is high.
  - The event entry is {`count_i`, `ts` (current value), `wrap`}.
  - `wrap` is 1 only when `prev_count == 8'hFF` and `count_i == 8'h00`.
  - Any other jump, such as an upstream reset from 0x37 to 0x00, records `wrap` = 0.
- An event is pushed into the FIFO if the FIFO is not full, or if it is full and a pop happens in the same cycle. In the full-with-pop case, `level_o` is unchanged.
- An event is dropped if the FIFO is full and no pop happens in that cycle. A drop sets `overflow_o`, which stays set until `clear_i` or reset.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves `level_o` unchanged.
- `event_valid_o` = (`level_o` != 0).
- A pop occurs when `event_valid_o && event_ready_i`.
- While `event_valid_o` is high and `event_ready_i` is low, all `event_*_o` outputs hold stable.
- When the FIFO is empty, the data outputs hold their last values; the consumer must ignore them.
- `threshold_hit_o` is registered. It is 1 in the cycle after a detected change with `count_i == threshold_i` and `capture_en_i` high. This happens whether the event is pushed or dropped.
- `clear_i` has priority over push and pop:
  - `level_o` goes to 0, `event_valid_o` goes to 0 and `overflow_o` goes to 0 on the next edge.
  - An event in the same cycle is discarded and does not set `overflow_o`.
  - `threshold_hit_o` still follows its normal rule.

## Timing
- Latency from change to valid is 1 cycle. `count_i` differs from `prev_count` in cycle k; with an empty FIFO, `event_valid_o` is high in cycle k+1.
- The counter's own output lags its increment condition by one cycle. This block adds no further lag.
- Throughput is one push and one pop per cycle. A consumer holding `event_ready_i` high drains one entry per cycle.
- No combinational path runs from `event_ready_i` to `event_valid_o`. The data outputs come from the FIFO read port or a register, never directly from `count_i`.
- Deasserting reset mid-operation restarts from the all-zero state. An upstream `count_i` that is nonzero at that point produces one event on the first edge.

## Structure
- Package `count_event_pkg` holds:
  - the `count_event_t` packed struct {count[7:0], ts[TS_WIDTH-1:0], wrap}, using the default `TS_WIDTH`;
  - the localparam `COUNT_WIDTH` = 8;
  - the wrap constants 8'hFF and 8'h00.
- Sub-module `event_fifo` is a parameterised synchronous FIFO. It has data width, `DEPTH`, push, pop, flush, full, empty and level, and uses pointers one bit wider than the address. The top level contains change detection, `ts`, the threshold logic, the overflow flag and the push/drop decision.

## Test plan
- **Reset:** drive `count_i` = 0, assert and release `reset_ni`. Require all outputs 0, no event, and `level_o` = 0.
- **Single event:** `capture_en_i` = 1, `event_ready_i` = 0, `count_i` steps 0→1 at `ts` = 5. In the next cycle require `event_valid_o` = 1, count = 1, ts = 5, wrap = 0, `level_o` = 1. Then pulse `event_ready_i` and require valid = 0.
- **Wrap:** `count_i` steps 0xFF→0x00. Require an event with wrap = 1. Then force 0x37→0x00 and require wrap = 0.
- **Full and overflow:** `DEPTH` = 4, ready = 0, six changes. Require `level_o` = 4, entries 1–4 in order, and `overflow_o` = 1. Then assert `clear_i` together with a change. Require `level_o` = 0, `overflow_o` = 0, and no entry pushed.
- **Full push+pop:** with a full FIFO, change `count_i` with ready = 1 in the same cycle. Require the event accepted, `level_o` = 4, and `overflow_o` unchanged.
- **Threshold:** `threshold_i` = 3, `capture_en_i` = 1, `count_i` steps 2→3. Require `threshold_hit_o` high for exactly one cycle. Repeat with `capture_en_i` = 0 and require no pulse and no event.
